// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky
// illegal-opcode and memory-timeout traps plus a retired-instruction counter.
module riscv_multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             Branch,
    output logic             Jump,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t     st, nx;
    logic [6:0] op_q;
    logic [7:0] wcnt, wcnt_d;
    logic       set_ill, set_to, req, wait_hit, legal;
    logic       is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;

    assign state    = st;
    assign is_i     = (op_q == OP_I);
    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_br    = (op_q == OP_BR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign legal    = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                                     OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    // Ready in the last allowed wait cycle wins over the timeout
    assign wait_hit = (wcnt == 8'(TIMEOUT - 1)) && !mem_ready;

    always_comb begin
        nx       = st;
        set_ill  = 1'b0;
        set_to   = 1'b0;
        req      = 1'b0;
        mem_we   = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        unique case (st)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    nx       = S_DECODE;
                end else if (wait_hit) begin
                    set_to = 1'b1;
                    nx     = S_TRAP;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    nx = S_EXEC;
                end else begin
                    set_ill = 1'b1;
                    nx      = S_TRAP;
                end
            end
            S_EXEC: begin
                ALUSrc = is_i | is_ld | is_st | is_lui | is_auipc | is_jalr;
                if (is_br) begin
                    ALUOp    = 2'b01;
                    Branch   = 1'b1;
                    pc_write = 1'b1;
                    nx       = S_FETCH;
                end else if (is_ld || is_st) begin
                    ALUOp = 2'b10;
                    nx    = S_MEM;
                end else begin
                    nx = S_WB;
                end
            end
            S_MEM: begin
                req      = 1'b1;
                ALUOp    = 2'b10;
                ALUSrc   = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_st;
                mem_we   = is_st;
                if (mem_ready) begin
                    if (is_st) begin
                        pc_write = 1'b1;
                        nx       = S_FETCH;
                    end else begin
                        nx = S_WB;
                    end
                end else if (wait_hit) begin
                    set_to = 1'b1;
                    nx     = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
                Jump     = is_jal | is_jalr;
                nx       = S_FETCH;
            end
            S_TRAP: nx = S_TRAP;
            default: nx = S_FETCH;
        endcase

        wcnt_d = (req && !mem_ready && nx == st) ? wcnt + 8'd1 : 8'd0;

        if (rst) begin
            req      = 1'b0;
            mem_we   = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            Branch   = 1'b0;
            Jump     = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            ALUSrc   = 1'b0;
            ALUOp    = 2'b00;
        end
    end

    assign mem_req = req;

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_FETCH;
            op_q    <= 7'd0;
            wcnt    <= 8'd0;
            retired <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            st   <= nx;
            wcnt <= wcnt_d;
            if (st == S_DECODE) op_q <= opcode;
            if (set_ill) illegal <= 1'b1;
            if (set_to) timeout <= 1'b1;
            if (pc_write) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: doc/riscv_multicycle_control.md
RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which is the maximum number of wait cycles on mem_ready per access (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, which is the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port opcode, input, 7 bits: instruction[6:0], sampled in DECODE.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory acknowledge for the current mem_req.
REQ-007 SHALL have port state, output, 3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-008 SHALL have output ports mem_req, mem_we, ir_write and pc_write, each 1 bit: memory request, memory write, instruction-register load and PC update.
REQ-009 SHALL have output ports Branch, Jump, RegWrite, MemRead, MemWrite and ALUSrc, each 1 bit: datapath strobes.
REQ-010 SHALL have port ALUOp, output, 2 bits: 00 arithmetic, 01 branch compare, 10 address add.
REQ-011 SHALL have output ports illegal and timeout, each 1 bit: sticky fault flags.
REQ-012 SHALL have port retired, output, CNT_W bits: count of completed instructions.

Function
REQ-013 SHALL derive all strobes combinationally from state and the opcode latched in DECODE (op_q); there SHALL be no combinational path from opcode to any output.
REQ-014 SHALL treat these as legal opcodes: 0110011 R, 0010011 I-arith, 0000011 load, 0100011 store, 1100011 branch, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR; every other opcode is illegal.
REQ-015 In FETCH: mem_req=1 and mem_we=0; on mem_ready=1, ir_write=1 for that cycle and the next state is DECODE.
REQ-016 In DECODE: op_q SHALL capture opcode; an illegal opcode SHALL go to TRAP and set illegal; otherwise the next state is EXEC.
REQ-017 In EXEC: ALUOp SHALL be 01 for branch, 10 for load/store and 00 otherwise; ALUSrc=1 for I-arith, load, store, LUI, AUIPC and JALR.
REQ-018 EXEC transitions: branch SHALL assert Branch=1 and pc_write=1 and return to FETCH; load/store SHALL go to MEM; all other instructions SHALL go to WB.
REQ-019 In MEM: mem_req=1, with MemRead=1 for a load and MemWrite=1 plus mem_we=1 for a store; ALUOp=10 and ALUSrc=1 SHALL be held.
REQ-020 MEM transitions on mem_ready: a store SHALL assert pc_write=1 and return to FETCH; a load SHALL go to WB.
REQ-021 In WB: RegWrite=1 and pc_write=1 for one cycle, with Jump=1 for JAL/JALR; the next state is FETCH.
REQ-022 Every WB and MEM state SHALL last exactly 1 cycle when mem_ready is already 1; minimum latencies are R/I/LUI/AUIPC/JAL/JALR 4 cycles, branch 3, store 4, load 5.
REQ-023 A wait counter SHALL clear on entry to FETCH/MEM and on mem_ready, and increment each cycle mem_req=1 with mem_ready=0.
REQ-024 When the wait counter reaches TIMEOUT, the next state SHALL be TRAP and timeout SHALL be set; mem_ready in that same cycle SHALL take priority, so there is no timeout.
REQ-025 retired SHALL increment by 1 on every cycle with pc_write=1 and wrap from 2^CNT_W-1 to 0.
REQ-026 TRAP SHALL be absorbing: all strobes and mem_req are 0, and the state is held until rst.
REQ-027 illegal and timeout SHALL remain set until rst, and SHALL never both be set by one instruction.
REQ-028 mem_ready SHALL be ignored in DECODE, EXEC, WB and TRAP.

Reset
REQ-029 On a rising clk edge with rst=1: state=FETCH, op_q=0, wait counter=0, retired=0, illegal=0, timeout=0.
REQ-030 While rst=1, all strobes, mem_req, mem_we, ir_write and pc_write SHALL be forced to 0.
REQ-031 Reset asserted mid-instruction (including MEM with a pending request or TRAP) SHALL abandon the instruction without incrementing retired; the first cycle after rst falls SHALL be FETCH with mem_req=1.

Verification
REQ-032 Bench SHALL apply ADD 0110011 with mem_ready tied 1 and check states 0,1,2,4,0; RegWrite=1 only in the WB cycle; retired=1 after 4 cycles.
REQ-033 Bench SHALL apply a load, then a store, with mem_ready tied 1 and check load MemRead=1 in MEM and RegWrite=1 in WB, 5 cycles; store mem_we=1 in MEM, no WB, 4 cycles; retired=2.
REQ-034 Bench SHALL apply BEQ 1100011 and check Branch=1, ALUOp=01 and pc_write=1 in EXEC; 3 cycles; RegWrite never asserted.
REQ-035 Bench SHALL apply opcode 1111111 and check state=5 and illegal=1 after DECODE, all strobes 0 for 20 cycles, and retired unchanged.
REQ-036 Bench SHALL hold mem_ready=0 in FETCH with TIMEOUT=16 and check TRAP with timeout=1 after 16 wait cycles; a second run with mem_ready=1 on wait cycle 16 SHALL reach DECODE with no timeout.
REQ-037 Bench SHALL preset retired to all-ones (CNT_W=4, 15 instructions) and check that the next retire gives 0, then assert rst in MEM and check FETCH and all flags 0 on the next edge.
